// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA state encoding, default MISR constants matching the
// pattern-generator stage, and the MISR step function.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ora_state_t;

  localparam int         BIST_WIDTH  = 4;
  localparam int         MISR_MAX_W  = 32;
  localparam logic [3:0] BIST_POLY   = 4'b0011;  // x^4+x+1, x^4 term implied
  localparam logic [3:0] BIST_SEED   = 4'h0;
  localparam logic [3:0] BIST_GOLDEN = 4'h0;

  // One MISR step on the low w bits: shift left, fold the MSB back through poly, xor in resp.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [MISR_MAX_W-1:0] resp,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic                  msb;
    mask = ~({MISR_MAX_W{1'b1}} << w);
    msb  = |(sig & (MISR_MAX_W'(1) << (w - 1)));
    return ((sig << 1) ^ (msb ? poly : '0) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// MISR signature register: synchronous load of SEED, compaction step when enabled.
// o_next exposes the would-be next signature so the caller can judge the final step.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = BIST_POLY,
  parameter logic [WIDTH-1:0] SEED  = BIST_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0]      r_sig;
  logic [MISR_MAX_W-1:0] w_next_full;

  assign w_next_full = misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(POLY),
                                 MISR_MAX_W'(i_data), WIDTH);
  assign o_next = w_next_full[WIDTH-1:0];
  assign o_sig  = r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sig <= SEED;
    else if (i_load) r_sig <= SEED;
    else if (i_en)   r_sig <= o_next;
  end

endmodule

// File: rtl/bist_misr_ora.sv
// BIST output response analyser: compacts PATTERNS CUT responses into a MISR and compares
// against GOLDEN. Optional X-masking input resp_mask when BIST_ORA_MASK_EN is defined.
module bist_misr_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH    = BIST_WIDTH,
  parameter int               PATTERNS = 16,
  parameter logic [WIDTH-1:0] POLY     = BIST_POLY,
  parameter logic [WIDTH-1:0] SEED     = BIST_SEED,
  parameter logic [WIDTH-1:0] GOLDEN   = BIST_GOLDEN,
  localparam int              CW       = $clog2(PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_i,
`ifdef BIST_ORA_MASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    pat_cnt
);

  ora_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done, r_pass;
  logic [WIDTH-1:0] w_data, w_sig_next;
  logic             w_start, w_step, w_last;

`ifdef BIST_ORA_MASK_EN
  assign w_data = resp_i & ~resp_mask;
`else
  assign w_data = resp_i;
`endif

  // start is only honoured outside RUN; a response in the start cycle is dropped
  assign w_start = start && (r_state != RUN);
  assign w_step  = resp_valid && (r_state == RUN);
  assign w_last  = w_step && (r_cnt == CW'(PATTERNS - 1));

  bist_misr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_en   (w_step),
    .i_data (w_data),
    .o_sig  (signature),
    .o_next (w_sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        RUN: begin
          if (w_step && r_cnt != CW'(PATTERNS)) r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_sig_next == GOLDEN);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign pat_cnt = r_cnt;

endmodule

// File: tb/tb_bist_misr_ora.sv
// Directed bench for bist_misr_ora (WIDTH=4, PATTERNS=16, poly x^4+x+1, SEED=GOLDEN=0).
// Expected signatures are powers of x mod x^4+x+1, worked out by hand.
module tb_bist_misr_ora;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       resp_valid;
  logic [3:0] resp_i;
  logic [3:0] resp_mask;
  logic       busy, done, pass;
  logic [3:0] signature;
  logic [4:0] pat_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bist_misr_ora dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .resp_valid (resp_valid),
    .resp_i     (resp_i),
`ifdef BIST_ORA_MASK_EN
    .resp_mask  (resp_mask),
`endif
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pat_cnt    (pat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic st, input logic v, input logic [3:0] d);
    start      = st;
    resp_valid = v;
    resp_i     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic dn, input logic p,
                         input logic [3:0] s, input logic [4:0] c);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".pass"}, 32'(pass), 32'(p));
    chk({tag, ".sig"},  32'(signature), 32'(s));
    chk({tag, ".cnt"},  32'(pat_cnt), 32'(c));
  endtask

  // x^k mod x^4+x+1 for k = 0..15
  logic [3:0] xpow [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                            4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

  initial begin
    rst_n = 1'b0; start = 1'b0; resp_valid = 1'b0; resp_i = 4'h0; resp_mask = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 5'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 4'hA);
    chk_all("idle_ignore", 1'b0, 1'b0, 1'b0, 4'h0, 5'd0);

    // start with a response in the same cycle: the response is dropped
    cyc(1'b1, 1'b1, 4'h5);
    chk_all("start", 1'b1, 1'b0, 1'b0, 4'h0, 5'd0);
    cyc(1'b0, 1'b1, 4'h1);
    for (int k = 1; k < 5; k++) cyc(1'b0, 1'b1, 4'h0);
    chk_all("run5", 1'b1, 1'b0, 1'b0, 4'h3, 5'd5);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 4'h0, 5'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 16 zero responses -> signature 0, pass
    cyc(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b1, 4'h0);
    chk_all("zeros15", 1'b1, 1'b0, 1'b0, 4'h0, 5'd15);
    cyc(1'b0, 1'b1, 4'h0);
    chk_all("zeros16", 1'b0, 1'b1, 1'b1, 4'h0, 5'd16);
    cyc(1'b0, 1'b1, 4'hF);
    chk_all("done_hold", 1'b0, 1'b1, 1'b1, 4'h0, 5'd16);

    // start in DONE restarts; start held high through RUN is ignored
    cyc(1'b1, 1'b0, 4'h0);
    chk_all("restart", 1'b1, 1'b0, 1'b0, 4'h0, 5'd0);
    cyc(1'b1, 1'b1, 4'h1);
    chk("impulse.sig0", 32'(signature), 32'(xpow[0]));
    for (int k = 1; k < 16; k++) begin
      cyc(1'b1, 1'b1, 4'h0);
      if (k == 7)  chk("impulse.sig7", 32'(signature), 32'(xpow[7]));
      if (k == 14) chk_all("impulse15", 1'b1, 1'b0, 1'b0, xpow[14], 5'd15);
    end
    chk_all("impulse16", 1'b0, 1'b1, 1'b0, 4'h1, 5'd16);

    // same stream with idle gaps carrying junk data
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    chk_all("gap_start", 1'b1, 1'b0, 1'b0, 4'h0, 5'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, (k == 0) ? 4'h1 : 4'h0);
      if (k == 15) chk_all("gap16", 1'b0, 1'b1, 1'b0, 4'h1, 5'd16);
      else begin
        cyc(1'b0, 1'b0, 4'hF);
        if (k == 4)  chk_all("gap_hold", 1'b1, 1'b0, 1'b0, xpow[4], 5'd5);
        if (k == 14) chk_all("gap15", 1'b1, 1'b0, 1'b0, xpow[14], 5'd15);
      end
    end

`ifdef BIST_ORA_MASK_EN
    resp_mask = 4'hF;
    cyc(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 4'(k * 7 + 3));
    chk_all("mask16", 1'b0, 1'b1, 1'b1, 4'h0, 5'd16);
    resp_mask = 4'h0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
